// File: rtl/id_operand_unit_if.sv
// Operand-side signal bundle of the decode stage: writeback buses, register
// reads, immediate controls, pipeline controls and the resolved operands.
interface id_operand_unit_if;
    logic [37:0] MEM_BACK;
    logic [37:0] WB_BACK;
    logic        USE_MEM_BACK;
    logic        USE_WB_BACK;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [15:0] imm;
    logic        extop;
    logic        exsign;
    logic [2:0]  branchType;
    logic        flush;
    logic        en;
    logic [31:0] f_rd1;
    logic [31:0] f_rd2;
    logic [31:0] ext_out;
    logic        branchAvail;
    logic [31:0] q_rd1;
    logic [31:0] q_rd2;
    logic [31:0] q_ext;

    modport master (
        output MEM_BACK, WB_BACK, USE_MEM_BACK, USE_WB_BACK,
        output rs, rt, rd1, rd2, imm, extop, exsign, branchType, flush, en,
        input  f_rd1, f_rd2, ext_out, branchAvail, q_rd1, q_rd2, q_ext
    );

    modport slave (
        input  MEM_BACK, WB_BACK, USE_MEM_BACK, USE_WB_BACK,
        input  rs, rt, rd1, rd2, imm, extop, exsign, branchType, flush, en,
        output f_rd1, f_rd2, ext_out, branchAvail, q_rd1, q_rd2, q_ext
    );
endinterface

// File: rtl/id_operand_unit.sv
// Decode-stage operand unit: bypasses MEM/WB results onto rs/rt, extends the
// immediate, resolves the branch condition and registers the operands for EX.
module id_operand_unit (
    input  logic               clk,
    input  logic               rst,
    id_operand_unit_if.slave   bus
);
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [4:0]  mem_rw;
    logic        wb_we;
    logic [31:0] wb_wd;
    logic [4:0]  wb_rw;

    assign mem_we = bus.MEM_BACK[37];
    assign mem_wd = bus.MEM_BACK[36:5];
    assign mem_rw = bus.MEM_BACK[4:0];
    assign wb_we  = bus.WB_BACK[37];
    assign wb_wd  = bus.WB_BACK[36:5];
    assign wb_rw  = bus.WB_BACK[4:0];

    logic [4:0]  src_num  [2];
    logic [31:0] src_data [2];
    logic [31:0] fwd_data [2];

    assign src_num[0]  = bus.rs;
    assign src_num[1]  = bus.rt;
    assign src_data[0] = bus.rd1;
    assign src_data[1] = bus.rd2;

    // Same bypass network for both source operands; MEM is younger so it wins.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            logic mem_hit;
            logic wb_hit;
            logic src_nz;

            assign src_nz  = |src_num[gi];
            assign mem_hit = bus.USE_MEM_BACK & mem_we & (mem_rw == src_num[gi]) & src_nz;
            assign wb_hit  = bus.USE_WB_BACK  & wb_we  & (wb_rw  == src_num[gi]) & src_nz;

            always_comb begin
                fwd_data[gi] = src_data[gi];
                if (mem_hit)
                    fwd_data[gi] = mem_wd;
                else if (wb_hit)
                    fwd_data[gi] = wb_wd;
            end
        end
    endgenerate

    assign bus.f_rd1 = fwd_data[0];
    assign bus.f_rd2 = fwd_data[1];

    logic [31:0] ext_val;

    always_comb begin
        ext_val = {16'h0000, bus.imm};
        if (bus.extop)
            ext_val = {bus.imm, 16'h0000};
        else if (bus.exsign)
            ext_val = {{16{bus.imm[15]}}, bus.imm};
    end

    assign bus.ext_out = ext_val;

    logic signed [31:0] op_a;
    logic signed [31:0] op_b;
    logic               taken;

    assign op_a = fwd_data[0];
    assign op_b = fwd_data[1];

    always_comb begin
        taken = 1'b0;
        case (bus.branchType)
            3'd1:    taken = (op_a == op_b);
            3'd2:    taken = (op_a != op_b);
            3'd3:    taken = (op_a <= 32'sd0);
            3'd4:    taken = (op_a >  32'sd0);
            3'd5:    taken = (op_a <  32'sd0);
            3'd6:    taken = (op_a >= 32'sd0);
            default: taken = 1'b0;
        endcase
    end

    assign bus.branchAvail = taken;

    logic [31:0] q_rd1_reg;
    logic [31:0] q_rd2_reg;
    logic [31:0] q_ext_reg;

    // Flush outranks enable so a squashed slot always leaves EX with zeros.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_rd1_reg <= 32'h0;
            q_rd2_reg <= 32'h0;
            q_ext_reg <= 32'h0;
        end else if (bus.flush) begin
            q_rd1_reg <= 32'h0;
            q_rd2_reg <= 32'h0;
            q_ext_reg <= 32'h0;
        end else if (bus.en) begin
            q_rd1_reg <= fwd_data[0];
            q_rd2_reg <= fwd_data[1];
            q_ext_reg <= ext_val;
        end
    end

    assign bus.q_rd1 = q_rd1_reg;
    assign bus.q_rd2 = q_rd2_reg;
    assign bus.q_ext = q_ext_reg;
endmodule

// File: tb/tb_id_operand_unit.sv
// Directed bench for id_operand_unit: forwarding, extension, branch decode
// and the registered operand stage including asynchronous reset.
module tb_id_operand_unit;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    id_operand_unit_if bus ();

    id_operand_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("step %-16s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        bus.MEM_BACK = '0;  bus.WB_BACK = '0;
        bus.USE_MEM_BACK = 1'b0;  bus.USE_WB_BACK = 1'b0;
        bus.rs = 5'd0;  bus.rt = 5'd0;  bus.rd1 = '0;  bus.rd2 = '0;
        bus.imm = '0;  bus.extop = 1'b0;  bus.exsign = 1'b0;
        bus.branchType = 3'd0;  bus.flush = 1'b0;  bus.en = 1'b0;
        #3;
        chk("rst_q_rd1", bus.q_rd1, 32'h0);
        chk("rst_q_rd2", bus.q_rd2, 32'h0);
        chk("rst_q_ext", bus.q_ext, 32'h0);

        // Forwarding priority on rs
        bus.rs = 5'd5;  bus.rd1 = 32'd1;
        bus.MEM_BACK = {1'b1, 32'hAAAA0000, 5'd5};
        bus.WB_BACK  = {1'b1, 32'hBBBB0000, 5'd5};
        bus.USE_MEM_BACK = 1'b1;  bus.USE_WB_BACK = 1'b1;
        #1 chk("fwd_mem_wins", bus.f_rd1, 32'hAAAA0000);
        chk("comb_in_reset", bus.f_rd1, 32'hAAAA0000);
        bus.USE_MEM_BACK = 1'b0;
        #1 chk("fwd_wb", bus.f_rd1, 32'hBBBB0000);
        bus.USE_MEM_BACK = 1'b1;
        bus.MEM_BACK = {1'b0, 32'hAAAA0000, 5'd5};
        bus.WB_BACK  = {1'b1, 32'hBBBB0000, 5'd6};
        #1 chk("fwd_none", bus.f_rd1, 32'd1);
        bus.WB_BACK  = {1'b0, 32'hBBBB0000, 5'd5};
        #1 chk("wb_regwrite0", bus.f_rd1, 32'd1);

        // rt path: WB forwards while MEM targets another register
        bus.rt = 5'd9;  bus.rd2 = 32'h0000_0099;
        bus.MEM_BACK = {1'b1, 32'hCAFE0001, 5'd8};
        bus.WB_BACK  = {1'b1, 32'hDEAD0002, 5'd9};
        #1 chk("fwd_rt_wb", bus.f_rd2, 32'hDEAD0002);
        bus.MEM_BACK = {1'b1, 32'hCAFE0001, 5'd9};
        #1 chk("fwd_rt_mem", bus.f_rd2, 32'hCAFE0001);

        // Register 0 never forwarded
        bus.rs = 5'd0;  bus.rd1 = 32'd0;  bus.rt = 5'd0;  bus.rd2 = 32'd0;
        bus.MEM_BACK = {1'b1, 32'h12345678, 5'd0};
        bus.WB_BACK  = {1'b1, 32'h87654321, 5'd0};
        #1 chk("r0_rs", bus.f_rd1, 32'h0);
        chk("r0_rt", bus.f_rd2, 32'h0);

        // Immediate extension
        bus.imm = 16'h8001;  bus.exsign = 1'b1;
        #1 chk("ext_sign", bus.ext_out, 32'hFFFF8001);
        bus.exsign = 1'b0;
        #1 chk("ext_zero", bus.ext_out, 32'h00008001);
        bus.extop = 1'b1;  bus.exsign = 1'b1;
        #1 chk("ext_lui", bus.ext_out, 32'h80010000);
        bus.extop = 1'b0;  bus.imm = 16'h7FFF;
        #1 chk("ext_sign_pos", bus.ext_out, 32'h00007FFF);

        // Branch decode, no forwarding
        bus.USE_MEM_BACK = 1'b0;  bus.USE_WB_BACK = 1'b0;
        bus.rs = 5'd1;  bus.rt = 5'd2;  bus.rd1 = 32'd7;  bus.rd2 = 32'd7;
        bus.branchType = 3'd1;  #1 chk("br_eq_t", {31'h0, bus.branchAvail}, 32'd1);
        bus.branchType = 3'd2;  #1 chk("br_ne_f", {31'h0, bus.branchAvail}, 32'd0);
        bus.rd2 = 32'd8;        #1 chk("br_ne_t", {31'h0, bus.branchAvail}, 32'd1);
        bus.branchType = 3'd1;  #1 chk("br_eq_f", {31'h0, bus.branchAvail}, 32'd0);
        bus.rd1 = 32'hFFFFFFFF;
        bus.branchType = 3'd5;  #1 chk("br_lt_neg", {31'h0, bus.branchAvail}, 32'd1);
        bus.branchType = 3'd4;  #1 chk("br_gt_neg", {31'h0, bus.branchAvail}, 32'd0);
        bus.branchType = 3'd3;  #1 chk("br_le_neg", {31'h0, bus.branchAvail}, 32'd1);
        bus.branchType = 3'd6;  #1 chk("br_ge_neg", {31'h0, bus.branchAvail}, 32'd0);
        bus.rd1 = 32'd0;        #1 chk("br_ge_zero", {31'h0, bus.branchAvail}, 32'd1);
        bus.branchType = 3'd3;  #1 chk("br_le_zero", {31'h0, bus.branchAvail}, 32'd1);
        bus.branchType = 3'd4;  #1 chk("br_gt_zero", {31'h0, bus.branchAvail}, 32'd0);
        bus.rd1 = 32'd5;        #1 chk("br_gt_pos", {31'h0, bus.branchAvail}, 32'd1);
        bus.branchType = 3'd3;  #1 chk("br_le_pos", {31'h0, bus.branchAvail}, 32'd0);
        bus.branchType = 3'd7;  #1 chk("br_type7", {31'h0, bus.branchAvail}, 32'd0);
        bus.rd2 = 32'd5;
        bus.branchType = 3'd0;  #1 chk("br_type0", {31'h0, bus.branchAvail}, 32'd0);

        // Branch resolved through forwarding
        bus.rs = 5'd4;  bus.rd1 = 32'd0;  bus.rt = 5'd2;  bus.rd2 = 32'd3;
        bus.MEM_BACK = {1'b1, 32'd3, 5'd4};  bus.USE_MEM_BACK = 1'b1;
        bus.branchType = 3'd1;
        #1 chk("br_fwd_eq", {31'h0, bus.branchAvail}, 32'd1);

        // Register stage: held in reset across an edge
        bus.USE_MEM_BACK = 1'b0;
        bus.rs = 5'd1;  bus.rd1 = 32'h11;  bus.rt = 5'd2;  bus.rd2 = 32'h22;
        bus.imm = 16'h0033;  bus.extop = 1'b0;  bus.exsign = 1'b0;  bus.en = 1'b1;
        @(posedge clk); #1;
        chk("rst_hold_q_rd1", bus.q_rd1, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("cap_q_rd1", bus.q_rd1, 32'h11);
        chk("cap_q_rd2", bus.q_rd2, 32'h22);
        chk("cap_q_ext", bus.q_ext, 32'h33);

        bus.en = 1'b0;  bus.rd1 = 32'h44;  bus.rd2 = 32'h55;  bus.imm = 16'h0066;
        @(posedge clk); #1;
        chk("hold_q_rd1", bus.q_rd1, 32'h11);
        chk("hold_q_rd2", bus.q_rd2, 32'h22);
        chk("hold_q_ext", bus.q_ext, 32'h33);

        bus.flush = 1'b1;  bus.en = 1'b1;
        @(posedge clk); #1;
        chk("flush_q_rd1", bus.q_rd1, 32'h0);
        chk("flush_q_rd2", bus.q_rd2, 32'h0);
        chk("flush_q_ext", bus.q_ext, 32'h0);

        bus.flush = 1'b0;
        @(posedge clk); #1;
        chk("recap_q_rd1", bus.q_rd1, 32'h44);
        chk("recap_q_ext", bus.q_ext, 32'h66);

        // Asynchronous reset mid-cycle
        #2 rst = 1'b0;
        #1;
        chk("async_q_rd1", bus.q_rd1, 32'h0);
        chk("async_q_rd2", bus.q_rd2, 32'h0);
        chk("async_q_ext", bus.q_ext, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("resume_q_rd2", bus.q_rd2, 32'h55);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_operand_unit.md
ID_OPERAND_UNIT -- requirements
Module: id_operand_unit

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 MEM_BACK  input  38  MEM-stage writeback bus {regWrite[37], Wd[36:5], rw[4:0]}.
REQ-005 WB_BACK  input  38  WB-stage writeback bus, same packing as MEM_BACK.
REQ-006 USE_MEM_BACK  input  1  enables forwarding from MEM_BACK.
REQ-007 USE_WB_BACK  input  1  enables forwarding from WB_BACK.
REQ-008 rs, rt  input  5 each  source register numbers.
REQ-009 rd1, rd2  input  32 each  register-file read data for rs, rt.
REQ-010 imm  input  16  instruction immediate.
REQ-011 extop  input  1  1 = load-upper form.
REQ-012 exsign  input  1  1 = sign extend, 0 = zero extend.
REQ-013 branchType  input  3  branch condition code.
REQ-014 flush, en  input  1 each  output-register clear and capture enable.
REQ-015 f_rd1, f_rd2  output  32 each  forwarded operands (combinational).
REQ-016 ext_out  output  32  extended immediate (combinational).
REQ-017 branchAvail  output  1  branch taken (combinational).
REQ-018 q_rd1, q_rd2, q_ext  output  32 each  registered copies of f_rd1, f_rd2, ext_out.

Function
REQ-019 f_rd1 SHALL be MEM_BACK.Wd if USE_MEM_BACK & MEM regWrite & MEM rw==rs & rs!=0; else WB_BACK.Wd if USE_WB_BACK & WB regWrite & WB rw==rs & rs!=0; else rd1.
REQ-020 f_rd2 SHALL follow REQ-019 with rt and rd2.
REQ-021 When MEM and WB both match, MEM SHALL win.
REQ-022 Register 0 SHALL never be forwarded, regardless of the Wd value on either bus.
REQ-023 A bus with regWrite=0 SHALL never forward, even on a register-number match.
REQ-024 ext_out SHALL be {imm,16'h0} when extop=1, ignoring exsign.
REQ-025 With extop=0, ext_out SHALL be {{16{imm[15]}},imm} when exsign=1 and {16'h0,imm} otherwise.
REQ-026 branchAvail SHALL be computed from f_rd1 (a) and f_rd2 (b), signed 32-bit compares, per branchType:
- 0: 0
- 1: a==b
- 2: a!=b
- 3: a<=0
- 4: a>0
- 5: a<0
- 6: a>=0
- 7: 0
REQ-027 Every combinational output SHALL settle within the same cycle as its inputs (zero latency); there SHALL be no combinational path from a registered output.
REQ-028 On a rising clk edge, flush=1 SHALL load zero into q_rd1, q_rd2, q_ext, with flush taking priority over en.
REQ-029 On a rising clk edge with flush=0 and en=1, the registers SHALL capture f_rd1, f_rd2, ext_out; with en=0 they SHALL hold.

Reset
REQ-030 rst=0 SHALL immediately clear q_rd1, q_rd2, q_ext to 0, independent of clk.
REQ-031 Registers SHALL stay cleared while rst=0; normal capture resumes on the first rising edge after rst returns high.
REQ-032 Combinational outputs SHALL be unaffected by rst.

Verification
REQ-033 Forwarding priority: rs=5, rd1=1, MEM={1,0xAAAA0000,5}, WB={1,0xBBBB0000,5}, both enables=1 -> f_rd1=0xAAAA0000; with USE_MEM_BACK=0 -> 0xBBBB0000; with MEM regWrite=0 and WB rw=6 -> 1.
REQ-034 Register 0: rs=0, rd1=0, MEM={1,0x12345678,0} -> f_rd1=0.
REQ-035 Extension: imm=0x8001 -> exsign=1 gives 0xFFFF8001; exsign=0 gives 0x00008001; extop=1 gives 0x80010000.
REQ-036 Branch:
- a=b=7, type 1 -> 1; type 2 -> 0.
- a=0xFFFFFFFF: type 5 -> 1, type 4 -> 0, type 3 -> 1.
- a=0: type 6 -> 1.
- type 7 -> 0.
REQ-037 Branch via forwarding: rd1=0, rd2=3, MEM forwards 3 to rs, type 1 -> branchAvail=1.
REQ-038 Register stage:
- en=1 captures 0x11/0x22/0x33 on one edge.
- en=0 holds through the next edge.
- flush=1 with en=1 -> all 0.
- rst low mid-cycle -> all 0 before the next edge.
